// File: rtl/pll_lock_supervisor.sv
// PLL reset/lock supervisor: holds the PLL in reset, waits for a stable lock, then releases
// the system reset; retries on timeout and faults when the retries run out. Optional macro: PLL_SUP_LOSS_CNT_EN.
module pll_lock_supervisor #(
  parameter int PLL_RST_CYCLES      = 16,
  parameter int LOCK_STABLE_CYCLES  = 1024,
  parameter int LOCK_TIMEOUT_CYCLES = 50000,
  parameter int MAX_RETRIES         = 7,
  parameter int CNT_W               = 16
) (
  input  logic       refclk_i,
  input  logic       rst_i,
  input  logic       pll_locked_i,
  input  logic       soft_reset_i,
  output logic       pll_rst_o,
  output logic       sys_rst_o,
  output logic       ready_o,
  output logic       fault_o,
  output logic [2:0] retry_cnt_o,
`ifdef PLL_SUP_LOSS_CNT_EN
  output logic [7:0] loss_cnt_o,
`endif
  output logic [1:0] state_o
);

  typedef enum logic [1:0] {
    PLL_RST   = 2'd0,
    WAIT_LOCK = 2'd1,
    RUN       = 2'd2,
    FAULT     = 2'd3
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   phase_cnt_q, phase_cnt_d;
  logic [CNT_W-1:0]   stb_cnt_q, stb_cnt_d;
  logic [2:0]         retry_q, retry_d;
  logic               sync1_q, locked_s_q;
  logic               pll_rst_q, sys_rst_q, ready_q, fault_q;
  logic               loss_event;

  // pll_locked is asynchronous to refclk
  always_ff @(posedge refclk_i) begin
    if (rst_i) begin
      sync1_q    <= 1'b0;
      locked_s_q <= 1'b0;
    end else begin
      sync1_q    <= pll_locked_i;
      locked_s_q <= sync1_q;
    end
  end

  always_comb begin
    state_d     = state_q;
    phase_cnt_d = phase_cnt_q;
    stb_cnt_d   = stb_cnt_q;
    retry_d     = retry_q;
    loss_event  = 1'b0;
    case (state_q)
      PLL_RST: begin
        if (phase_cnt_q == CNT_W'(PLL_RST_CYCLES - 1)) begin
          state_d     = WAIT_LOCK;
          phase_cnt_d = '0;
          stb_cnt_d   = '0;
        end else begin
          phase_cnt_d = phase_cnt_q + 1'b1;
        end
      end
      WAIT_LOCK: begin
        phase_cnt_d = phase_cnt_q + 1'b1;
        stb_cnt_d   = locked_s_q ? stb_cnt_q + 1'b1 : '0;
        // Stability wins over a timeout landing on the same cycle
        if (locked_s_q && stb_cnt_q == CNT_W'(LOCK_STABLE_CYCLES - 1)) begin
          state_d     = RUN;
          retry_d     = '0;
          phase_cnt_d = '0;
          stb_cnt_d   = '0;
        end else if (phase_cnt_q == CNT_W'(LOCK_TIMEOUT_CYCLES - 1)) begin
          phase_cnt_d = '0;
          stb_cnt_d   = '0;
          if (retry_q == 3'(MAX_RETRIES)) begin
            state_d = FAULT;
          end else begin
            state_d = PLL_RST;
            retry_d = retry_q + 1'b1;
          end
        end
      end
      RUN: begin
        if (!locked_s_q) begin
          state_d     = PLL_RST;
          phase_cnt_d = '0;
          stb_cnt_d   = '0;
          loss_event  = 1'b1;
        end
      end
      default: begin
      end
    endcase
    if (soft_reset_i) begin
      state_d     = PLL_RST;
      phase_cnt_d = '0;
      stb_cnt_d   = '0;
      retry_d     = '0;
      loss_event  = 1'b0;
    end
  end

  always_ff @(posedge refclk_i) begin
    if (rst_i) begin
      state_q     <= PLL_RST;
      phase_cnt_q <= '0;
      stb_cnt_q   <= '0;
      retry_q     <= '0;
      pll_rst_q   <= 1'b1;
      sys_rst_q   <= 1'b1;
      ready_q     <= 1'b0;
      fault_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      phase_cnt_q <= phase_cnt_d;
      stb_cnt_q   <= stb_cnt_d;
      retry_q     <= retry_d;
      // Outputs decoded from the next state so they move with the state register
      pll_rst_q   <= (state_d == PLL_RST) || (state_d == FAULT);
      sys_rst_q   <= (state_d != RUN);
      ready_q     <= (state_d == RUN);
      fault_q     <= (state_d == FAULT);
    end
  end

`ifdef PLL_SUP_LOSS_CNT_EN
  logic [7:0] loss_q;
  always_ff @(posedge refclk_i) begin
    if (rst_i) begin
      loss_q <= '0;
    end else if (loss_event && loss_q != 8'hFF) begin
      loss_q <= loss_q + 1'b1;
    end
  end
  assign loss_cnt_o = loss_q;
`else
  logic unused_loss;
  assign unused_loss = loss_event;
`endif

  assign pll_rst_o   = pll_rst_q;
  assign sys_rst_o   = sys_rst_q;
  assign ready_o     = ready_q;
  assign fault_o     = fault_q;
  assign retry_cnt_o = retry_q;
  assign state_o     = state_q;

endmodule

// File: doc/pll_lock_supervisor.md
Name: pll_lock_supervisor

Overview:
Controller on the driving side of the PLL's reset/locked interface. It asserts the PLL reset, waits for a stable lock, and only then releases the system reset. It re-locks on loss of lock and gives up with a fault flag after a bounded number of retries. Runs in the 50 MHz reference-clock domain and sits between the board reset and the PLL/SoC reset tree.

Parameters:
PLL_RST_CYCLES, 16, cycles pll_rst is held high per lock attempt (>=1)
LOCK_STABLE_CYCLES, 1024, consecutive synchronized-locked cycles required before release (>=1)
LOCK_TIMEOUT_CYCLES, 50000, cycles allowed per attempt in WAIT_LOCK before retry (1 ms @ 50 MHz)
MAX_RETRIES, 7, retries after the first attempt before FAULT (fits in 3 bits)
CNT_W, 16, width of the internal counters; must hold the largest cycle parameter

Ports:
refclk  in  1  reference clock, 50 MHz; the only clock
rst  in  1  synchronous, active-high reset
pll_locked  in  1  PLL locked output, asynchronous to refclk
soft_reset  in  1  synchronous, 1-cycle pulse: request re-lock / clear fault
pll_rst  out  1  reset to PLL, active-high
sys_rst  out  1  system reset, active-high; consumers re-synchronize into the outclk domain
ready  out  1  PLL locked and stable, system running
fault  out  1  retries exhausted
retry_cnt  out  3  retries used in the current lock sequence

Behaviour:
- pll_locked passes through a 2-flop synchronizer to give locked_s. Sync flops reset to 0.
- All outputs are registered and decoded from next-state, so they change on the same edge as the state register.
- States: PLL_RST, WAIT_LOCK, RUN, FAULT. Two counters: phase_cnt (reset/timeout) and stb_cnt (stability).
- On rst=1: state=PLL_RST, phase_cnt=0, stb_cnt=0, retry_cnt=0, pll_rst=1, sys_rst=1, ready=0, fault=0.
- PLL_RST: pll_rst=1, sys_rst=1. phase_cnt counts 0..PLL_RST_CYCLES-1. At the terminal count go to WAIT_LOCK and clear both counters.
- WAIT_LOCK: pll_rst=0, sys_rst=1.
  - phase_cnt increments every cycle.
  - stb_cnt increments while locked_s=1 and clears to 0 on any cycle with locked_s=0.
  - locked_s=1 and stb_cnt==LOCK_STABLE_CYCLES-1: go to RUN and clear retry_cnt. Stability beats timeout if both occur in the same cycle.
  - Else if phase_cnt==LOCK_TIMEOUT_CYCLES-1:
    - retry_cnt==MAX_RETRIES: go to FAULT.
    - Otherwise retry_cnt+1 and go to PLL_RST.
- RUN: pll_rst=0, sys_rst=0, ready=1.
  - locked_s=0 (lock loss): go to PLL_RST. sys_rst and pll_rst reassert on that edge. retry_cnt keeps its value (0).
- FAULT: pll_rst=1, sys_rst=1, ready=0, fault=1. Held until rst or soft_reset.
- soft_reset in any state: go to PLL_RST, clear counters, retry_cnt=0, fault=0. soft_reset overrides every other transition in the same cycle.
- rst mid-operation: immediate return to reset values on the next edge, regardless of state.
- Latency: locked_s rises 2 cycles after pll_locked. ready rises 2+LOCK_STABLE_CYCLES edges after a clean pll_locked rise in WAIT_LOCK.
- A glitch on pll_locked during WAIT_LOCK restarts the stability count but not the timeout.
- Counters never wrap: phase_cnt and stb_cnt are cleared on every state entry.

Optional Feature:
PLL_SUP_LOSS_CNT_EN
- Defined: adds output loss_cnt[7:0], reset 0. Increments on each RUN-to-PLL_RST transition caused by lock loss, saturating at 255. Cleared only by rst, not by soft_reset.
- Undefined: port and logic are absent. All other behaviour is identical.

Test Plan:
(Params: PLL_RST_CYCLES=4, LOCK_STABLE_CYCLES=8, LOCK_TIMEOUT_CYCLES=32, MAX_RETRIES=2.)
1. Release rst, drive pll_locked=1 from cycle 10 -> pll_rst high cycles 0-3 and low from cycle 4; ready=1 and sys_rst=0 exactly 10 edges after pll_locked rises; retry_cnt=0.
2. pll_locked held 0 -> retry_cnt steps 1, 2 at cycles 36 and 72; fault=1 and pll_rst=1 at cycle 108; ready stays 0 throughout.
3. In RUN, drop pll_locked for 1 cycle -> sys_rst=1 and pll_rst=1 2 edges later; with the macro defined, loss_cnt goes 0->1; re-lock gives ready again.
4. In WAIT_LOCK, pll_locked high 5 cycles, low 1, then high -> ready only 8 locked_s cycles after the glitch, provided the timeout has not expired.
5. In FAULT, pulse soft_reset -> next edge fault=0, retry_cnt=0, state PLL_RST; a normal lock follows.
6. Assert rst during WAIT_LOCK with retry_cnt=1 -> all outputs at reset values on the next edge; retry_cnt=0.
